lsu_byte_master: RTL and testbench

//  Load/store initiator for the MEM stage: accepts one word/halfword/byte access per request from the pipeline.

---
 rtl/lsu_byte_master.sv | 166 ++++++++++++++++
 tb/tb_lsu_byte_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_master.sv
// Load/store initiator: performs word/half/byte accesses as big-endian
// byte transfers on a req/ack memory port.
module lsu_byte_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_dsize,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [1:0]  dsize_q;
    logic [1:0]  idx_q;
    logic [7:0]  tmo_q;
    logic        write_q;
    logic        signed_q;
    logic        err_q;

    logic        misalign;
    logic        bad_req;
    logic        last_byte;
    logic        tmo_hit;
    logic [1:0]  wsel;
    logic [31:0] load_ext;

    assign misalign = ALIGN_CHECK &&
        ((req_dsize == 2'd3 && req_addr[1:0] != 2'd0) ||
         (req_dsize == 2'd1 && req_addr[0]));
    assign bad_req   = (req_dsize == 2'd2) || misalign;
    assign last_byte = (idx_q == dsize_q);
    assign tmo_hit   = (tmo_q == TMO_LAST);

    // Byte position of transfer idx within the right-aligned store field.
    assign wsel = 2'd3 - dsize_q + idx_q;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) state_nx = bad_req ? RESP : XFER;
            end
            XFER: begin
                if (mem_ack) begin
                    if (last_byte) state_nx = RESP;
                end else if (tmo_hit) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            wdata_q  <= '0;
            acc_q    <= '0;
            dsize_q  <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        dsize_q  <= req_dsize;
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        err_q    <= bad_req;
                        idx_q    <= '0;
                        tmo_q    <= '0;
                        acc_q    <= '0;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        acc_q <= {acc_q[23:0], mem_rdata};
                        idx_q <= idx_q + 2'd1;
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                        if (tmo_hit) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_ext = acc_q;
        unique case (dsize_q)
            2'd0:    load_ext = {{24{signed_q & acc_q[7]}}, acc_q[7:0]};
            2'd1:    load_ext = {{16{signed_q & acc_q[15]}}, acc_q[15:0]};
            default: load_ext = acc_q;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        unique case (state)
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = write_q;
                mem_addr = base_q + {30'd0, idx_q};
                unique case (wsel)
                    2'd0:    mem_wdata = wdata_q[31:24];
                    2'd1:    mem_wdata = wdata_q[23:16];
                    2'd2:    mem_wdata = wdata_q[15:8];
                    default: mem_wdata = wdata_q[7:0];
                endcase
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !write_q) resp_rdata = load_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench for lsu_byte_master: reference model predicts responses
// and byte transfers; monitor and memory responder check them.
module tb_lsu_byte_master;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_dsize = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;

    lsu_byte_master #(
        .TIMEOUT_CYCLES(4),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_dsize(req_dsize),
        .req_signed(req_signed),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .busy(busy),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_resp = 0;
    int resp_cyc = 0;
    int mreq_cycles = 0;
    int ack_mode = 0;
    int miss = 0;

    resp_t exp_q[$];
    xfer_t xq[$];
    logic [7:0] ref_mem[bit [31:0]];
    logic [7:0] dut_mem[bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input bit [31:0] a);
        return 8'(a * 13 + (a >> 8) + 32'h5A);
    endfunction

    function automatic logic [7:0] rd_ref(input bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] rd_dut(input bit [31:0] a);
        if (dut_mem.exists(a)) return dut_mem[a];
        return init_byte(a);
    endfunction

    // Reference model: big-endian byte sequence, then extension by arithmetic.
    function automatic resp_t model(input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [1:0] ds,
                                    input logic s);
        resp_t       r;
        int          n;
        logic [63:0] v;
        bit   [31:0] ai;
        logic [7:0]  b;
        n = ds + 1;
        v = '0;
        r.err = (ds == 2'd2) || (ds == 2'd3 && a % 4 != 0) ||
                (ds == 2'd1 && a % 2 != 0);
        r.rdata = '0;
        if (!r.err) begin
            for (int i = 0; i < n; i++) begin
                ai = a + i;
                if (w) begin
                    b = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
                    ref_mem[ai] = b;
                    xq.push_back({1'b1, ai, b});
                end else begin
                    v = v * 256 + rd_ref(ai);
                    xq.push_back({1'b0, ai, 8'h00});
                end
            end
            if (!w) begin
                if (s && v[8*n-1]) v = v - (64'd1 << (8 * n));
                r.rdata = v[31:0];
            end
        end
        return r;
    endfunction

    // Memory responder: random or forced ack, checks each byte transfer.
    xfer_t x;
    logic  go;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        if (mem_req) begin
            mreq_cycles++;
            chk("busy_in_xfer", busy, 1);
            go = (ack_mode == 1) ||
                 (ack_mode == 0 && (miss >= 2 || $urandom_range(0, 2) != 0));
            if (go) begin
                miss = 0;
                mem_ack = 1'b1;
                if (xq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: got addr %h, expected none",
                             mem_addr);
                end else begin
                    x = xq.pop_front();
                    chk("xfer_addr", mem_addr, x.addr);
                    chk("xfer_we", mem_we, x.we);
                    if (x.we) chk("xfer_wdata", mem_wdata, x.data);
                end
                if (mem_we) dut_mem[mem_addr] = mem_wdata;
                else mem_rdata = rd_dut(mem_addr);
            end else begin
                miss++;
            end
        end else if (ack_mode != 2) begin
            mem_ack = ($urandom_range(0, 3) == 0);
        end
    end

    resp_t e;
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            resp_cyc = cyc;
            chk("mem_req_in_resp", mem_req, 0);
            chk("ready_in_resp", req_ready, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got rdata %h, expected none",
                         resp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("resp_err", resp_err, e.err);
                chk("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] ds,
                         input logic s, output int lat);
        int start;
        int acc;
        exp_q.push_back(model(w, a, d, ds, s));
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_write = w;
        req_addr = a;
        req_wdata = d;
        req_dsize = ds;
        req_signed = s;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        start = n_resp;
        chk("busy_after_accept", busy, 1);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (n_resp != start) break;
            @(negedge clk);
            #1;
        end
        if (n_resp == start) begin
            checks++;
            errors++;
            $display("FAIL resp_wait: got no response, expected one");
            exp_q.delete();
            xq.delete();
        end else begin
            lat = resp_cyc + 1 - acc;
        end
    endtask

    task automatic poke(input bit [31:0] a, input logic [7:0] b);
        ref_mem[a] = b;
        dut_mem[a] = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          mr0;
        int          start;
        int          r;
        int          n;
        logic [1:0]  ds;
        logic [31:0] a;

        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        ack_mode = 1;
        poke(32'h100, 8'h12);
        poke(32'h101, 8'h34);
        poke(32'h102, 8'h56);
        poke(32'h103, 8'h78);
        issue(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, lat);
        chk("word_load_latency", lat, 5);

        poke(32'h40, 8'h80);
        poke(32'h41, 8'h01);
        poke(32'h42, 8'h7F);
        issue(1'b0, 32'h40, 32'h0, 2'd1, 1'b1, lat);
        issue(1'b0, 32'h40, 32'h0, 2'd1, 1'b0, lat);
        chk("half_load_latency", lat, 3);
        issue(1'b0, 32'h42, 32'h0, 2'd0, 1'b1, lat);
        issue(1'b0, 32'h40, 32'h0, 2'd0, 1'b1, lat);
        chk("byte_load_latency", lat, 2);

        issue(1'b1, 32'h7, 32'hAABBCCDD, 2'd0, 1'b0, lat);
        issue(1'b1, 32'h8, 32'hAABBCCDD, 2'd3, 1'b0, lat);
        issue(1'b1, 32'h12, 32'hAABBCCDD, 2'd1, 1'b0, lat);
        issue(1'b0, 32'h8, 32'h0, 2'd3, 1'b0, lat);
        issue(1'b0, 32'h4, 32'h0, 2'd3, 1'b1, lat);

        mr0 = mreq_cycles;
        issue(1'b0, 32'h102, 32'h0, 2'd3, 1'b0, lat);
        chk("misalign_latency", lat, 1);
        issue(1'b0, 32'h41, 32'h0, 2'd1, 1'b0, lat);
        issue(1'b1, 32'h20, 32'h1234, 2'd2, 1'b0, lat);
        chk("dsize2_latency", lat, 1);
        chk("err_no_mem_req", mreq_cycles, mr0);

        ack_mode = 2;
        mr0 = mreq_cycles;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        @(negedge clk);
        req_write = 1'b0;
        req_addr = 32'h200;
        req_dsize = 2'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        start = n_resp;
        for (int i = 0; i < 50 && n_resp == start; i++) begin
            @(negedge clk);
            #1;
        end
        chk("timeout_resp_seen", n_resp, start + 1);
        chk("timeout_wait_cycles", mreq_cycles - mr0, 4);

        ack_mode = 1;
        poke(32'h300, 8'hDE);
        poke(32'h301, 8'hAD);
        poke(32'h302, 8'hBE);
        poke(32'h303, 8'hEF);
        exp_q.push_back(model(1'b0, 32'h300, 32'h0, 2'd3, 1'b0));
        @(negedge clk);
        req_addr = 32'h300;
        req_dsize = 2'd3;
        req_write = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        start = n_resp;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        xq.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_resp", n_resp, start);
        rst_n = 1'b1;
        issue(1'b0, 32'h300, 32'h0, 2'd3, 1'b0, lat);
        chk("after_abort_latency", lat, 5);

        ack_mode = 0;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            ds = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd3 : 2'd2;
            n = ds + 1;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFC0 : 32'h0;
            a = a + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 1);
            issue(1'($urandom), a, $urandom, ds, 1'($urandom), lat);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty_resp", exp_q.size(), 0);
        chk("queue_empty_xfer", xq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
